// File: rtl/integral_pixel_feeder.sv
// Thresholds raster-order pixels into IntegralBuffer writes, tracks the fill level and
// stalls the pixel stream while the downstream classifier evaluates each complete window.
module integral_pixel_feeder #(
   parameter int ImageWidth  = 640,
   parameter int ImageHeight = 480,
   parameter int WindowSize  = 20,
   parameter int PixelWidth  = 8,
   parameter int Threshold   = 128
) (
   input  logic                             Clock,
   input  logic                             Reset,
   input  logic                             PixelValid,
   input  logic [PixelWidth-1:0]            PixelData,
   output logic                             PixelReady,
   output logic                             WriteEnable,
   output logic [$clog2(ImageWidth+1)-1:0]  Addr,
   output logic                             Data,
   output logic                             BufferClear,
   output logic                             EvalRequest,
   input  logic                             EvalDone,
   output logic [$clog2(ImageWidth+1)-1:0]  LastCol,
   output logic [$clog2(ImageHeight+1)-1:0] LastRow,
   output logic                             FrameDone
);
   localparam int ColWidth     = $clog2(ImageWidth+1);
   localparam int RowWidth     = $clog2(ImageHeight+1);
   localparam int FillCount    = ImageWidth*(WindowSize-1) + 2*WindowSize;
   localparam int WrittenWidth = $clog2(FillCount+1);

   localparam logic [ColWidth-1:0]     LastColIdx     = ColWidth'(ImageWidth-1);
   localparam logic [RowWidth-1:0]     LastRowIdx     = RowWidth'(ImageHeight-1);
   localparam logic [ColWidth-1:0]     MinEvalCol     = ColWidth'(2*WindowSize-1);
   localparam logic [WrittenWidth-1:0] FillTarget     = WrittenWidth'(FillCount);
   localparam logic [PixelWidth-1:0]   ThresholdValue = PixelWidth'(Threshold);

   typedef enum logic [2:0] {
      StClear  = 3'd0,
      StAccept = 3'd1,
      StWrite  = 3'd2,
      StSettle = 3'd3,
      StEval   = 3'd4
   } StateType;

   StateType                stateReg, stateNext;
   logic [ColWidth-1:0]     colReg;
   logic [RowWidth-1:0]     rowReg;
   logic [WrittenWidth-1:0] writtenReg;
   logic                    frameEndReg;
   logic [ColWidth-1:0]     addrReg;
   logic                    dataReg;
   logic [ColWidth-1:0]     lastColReg;
   logic [RowWidth-1:0]     lastRowReg;
   logic                    windowReady;

   // A window spanning a row wrap (newest column too small) is never evaluated.
   assign windowReady = (writtenReg >= FillTarget) && (lastColReg >= MinEvalCol);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         stateReg <= StClear;
      end else begin
         stateReg <= stateNext;
      end
   end

   always_comb begin
      stateNext = stateReg;
      unique case (stateReg)
         StClear:  stateNext = StAccept;
         StAccept: if (PixelValid) stateNext = StWrite;
         StWrite:  stateNext = StSettle;
         StSettle: begin
            if (windowReady)      stateNext = StEval;
            else if (frameEndReg) stateNext = StClear;
            else                  stateNext = StAccept;
         end
         StEval:   if (EvalDone) stateNext = frameEndReg ? StClear : StAccept;
         default:  stateNext = StClear;
      endcase
   end

   always_comb begin
      PixelReady  = 1'b0;
      WriteEnable = 1'b0;
      BufferClear = 1'b0;
      EvalRequest = 1'b0;
      FrameDone   = 1'b0;
      unique case (stateReg)
         StClear: begin
            BufferClear = 1'b1;
            FrameDone   = frameEndReg;
         end
         StAccept: PixelReady  = 1'b1;
         StWrite:  WriteEnable = 1'b1;
         StEval:   EvalRequest = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         colReg      <= '0;
         rowReg      <= '0;
         writtenReg  <= '0;
         frameEndReg <= 1'b0;
         addrReg     <= '0;
         dataReg     <= 1'b0;
         lastColReg  <= '0;
         lastRowReg  <= '0;
      end else begin
         unique case (stateReg)
            StClear: begin
               colReg      <= '0;
               rowReg      <= '0;
               writtenReg  <= '0;
               frameEndReg <= 1'b0;
            end
            StAccept: begin
               if (PixelValid) begin
                  addrReg <= colReg;
                  dataReg <= (PixelData >= ThresholdValue);
               end
            end
            StWrite: begin
               lastColReg <= colReg;
               lastRowReg <= rowReg;
               if (writtenReg != FillTarget) writtenReg <= writtenReg + 1'b1;
               if (colReg == LastColIdx) begin
                  colReg <= '0;
                  if (rowReg == LastRowIdx) begin
                     rowReg      <= '0;
                     frameEndReg <= 1'b1;
                  end else begin
                     rowReg <= rowReg + 1'b1;
                  end
               end else begin
                  colReg <= colReg + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign Addr    = addrReg;
   assign Data    = dataReg;
   assign LastCol = lastColReg;
   assign LastRow = lastRowReg;
endmodule

// File: tb/tb_integral_pixel_feeder.sv
// Bench for integral_pixel_feeder on an 8x6 image with 2x2 windows; expected writes and
// eval/frame events are queued at pixel acceptance and compared when the DUT responds.
module tb_integral_pixel_feeder;
   localparam int W    = 8;
   localparam int H    = 6;
   localparam int N    = 2;
   localparam int Fill = W*(N-1) + 2*N;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       PixelValid = 1'b0;
   logic [7:0] PixelData = 8'd0;
   logic       EvalDone = 1'b0;
   logic       PixelReady, WriteEnable, Data, BufferClear, EvalRequest, FrameDone;
   logic [3:0] Addr, LastCol;
   logic [2:0] LastRow;

   typedef struct {
      logic [3:0] addr;
      logic       data;
      logic [3:0] lastCol;
      logic [2:0] lastRow;
      logic       eval;
      logic       frameEnd;
   } ExpectType;

   ExpectType scoreboard[$];
   int vectorCount = 0;
   int miscompareCount = 0;
   int modelCol = 0;
   int modelRow = 0;
   int modelWritten = 0;
   int expWait = 0;

   integral_pixel_feeder #(
      .ImageWidth(W), .ImageHeight(H), .WindowSize(N), .PixelWidth(8), .Threshold(128)
   ) dut (
      .Clock(Clock), .Reset(Reset), .PixelValid(PixelValid), .PixelData(PixelData),
      .PixelReady(PixelReady), .WriteEnable(WriteEnable), .Addr(Addr), .Data(Data),
      .BufferClear(BufferClear), .EvalRequest(EvalRequest), .EvalDone(EvalDone),
      .LastCol(LastCol), .LastRow(LastRow), .FrameDone(FrameDone)
   );

   always #5 Clock = ~Clock;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectorCount++;
      if (got !== want) begin
         miscompareCount++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Entered at a falling edge; returns at the falling edge of the cycle after the pixel
   // is fully handled. doneDelay<0 asserts Reset during EVAL instead of EvalDone.
   task automatic sendPixel(input logic [7:0] pix, input int doneDelay);
      ExpectType e;
      ExpectType got;
      int waited = 0;
      PixelData  = pix;
      PixelValid = 1'b1;
      while (!PixelReady && waited < 20) begin
         @(negedge Clock);
         waited++;
      end
      if (!PixelReady) begin
         checkVal("ready_timeout", 0, 1);
         return;
      end
      checkVal("ready_wait", waited, expWait);

      e.addr         = 4'(modelCol);
      e.data         = (pix >= 8'd128);
      e.lastCol      = 4'(modelCol);
      e.lastRow      = 3'(modelRow);
      modelWritten   = (modelWritten < Fill) ? modelWritten + 1 : Fill;
      e.eval         = (modelWritten >= Fill) && (modelCol >= 2*N-1);
      e.frameEnd     = (modelCol == W-1) && (modelRow == H-1);
      if (modelCol == W-1) begin
         modelCol = 0;
         modelRow = (modelRow == H-1) ? 0 : modelRow + 1;
      end else begin
         modelCol++;
      end
      if (e.frameEnd) modelWritten = 0;
      scoreboard.push_back(e);

      @(negedge Clock);
      checkVal("write_en", WriteEnable, 1);
      checkVal("ready_in_write", PixelReady, 0);
      if (scoreboard.size() == 0) begin
         checkVal("scoreboard_empty", 0, 1);
         return;
      end
      got = scoreboard.pop_front();
      $display("pixel %0d -> addr %0d data %0d (exp %0d/%0d)", pix, Addr, Data, got.addr, got.data);
      checkVal("addr", Addr, got.addr);
      checkVal("data", Data, got.data);

      @(negedge Clock);
      checkVal("write_pulse_len", WriteEnable, 0);
      checkVal("ready_in_settle", PixelReady, 0);
      checkVal("last_col", LastCol, got.lastCol);
      checkVal("last_row", LastRow, got.lastRow);

      @(negedge Clock);
      checkVal("eval_req", EvalRequest, got.eval);
      if (got.eval) begin
         if (doneDelay < 0) begin
            Reset = 1'b1;
            #1;
            checkVal("eval_drop_on_reset", EvalRequest, 0);
            checkVal("clear_in_reset", BufferClear, 1);
            @(posedge Clock);
            #1 Reset = 1'b0;
            modelCol = 0;
            modelRow = 0;
            modelWritten = 0;
            scoreboard.delete();
            @(negedge Clock);
            checkVal("clear_after_reset", BufferClear, 1);
            checkVal("no_frame_done_reset", FrameDone, 0);
            expWait = 1;
            return;
         end
         for (int i = 0; i < doneDelay; i++) begin
            checkVal("eval_hold", EvalRequest, 1);
            checkVal("ready_in_eval", PixelReady, 0);
            @(negedge Clock);
         end
         EvalDone = 1'b1;
         @(negedge Clock);
         EvalDone = 1'b0;
      end
      checkVal("frame_done", FrameDone, got.frameEnd);
      checkVal("buffer_clear", BufferClear, got.frameEnd);
      expWait = got.frameEnd ? 1 : 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #2 Reset = 1'b1;
      @(negedge Clock);
      checkVal("rst_buffer_clear", BufferClear, 1);
      checkVal("rst_ready", PixelReady, 0);
      checkVal("rst_write_en", WriteEnable, 0);
      checkVal("rst_eval_req", EvalRequest, 0);
      checkVal("rst_frame_done", FrameDone, 0);
      checkVal("rst_addr", Addr, 0);
      checkVal("rst_data", Data, 0);
      checkVal("rst_last_col", LastCol, 0);
      checkVal("rst_last_row", LastRow, 0);
      @(posedge Clock);
      #1 Reset = 1'b0;
      @(negedge Clock);
      checkVal("post_rst_clear", BufferClear, 1);
      checkVal("post_rst_frame_done", FrameDone, 0);
      checkVal("post_rst_ready", PixelReady, 0);
      @(negedge Clock);
      checkVal("accept_ready", PixelReady, 1);
      checkVal("accept_clear", BufferClear, 0);
      checkVal("accept_frame_done", FrameDone, 0);
      checkVal("accept_eval_req", EvalRequest, 0);
      expWait = 0;

      sendPixel(8'd127, 0);
      sendPixel(8'd128, 0);
      for (int p = 3; p <= 60; p++) begin
         sendPixel(8'($urandom_range(0, 255)), (p == 12) ? 5 : int'($urandom_range(0, 2)));
      end
      sendPixel(8'd200, -1);
      sendPixel(8'd50, 0);
      sendPixel(8'd255, 0);
      sendPixel(8'd0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
      $finish;
   end
endmodule
